execute_muldiv_cycle: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly upstream of the memory cycle. It accepts one M-extension operation from the decode/execute pipeline, stalls the upstream pipeline while it computes, and registers the 32-bit result with its destination register and write-enable. The memory cycle consumes these as ALUResultM, RDM and RegWriteM.

---
 rtl/execute_muldiv_cycle.sv | 196 +++++++++++++++++++
 tb/tb_execute_muldiv_cycle.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_cycle.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide,
// with divide-by-zero and signed overflow resolved in one cycle.
module execute_muldiv_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [4:0]      RDE,
    input  logic [2:0]      RegWriteE,
    input  logic            FlushE,
    output logic            StallE,
    output logic [XLEN-1:0] ResultM,
    output logic [4:0]      RDM,
    output logic [2:0]      RegWriteM,
    output logic            ValidM
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  rw_q, rw_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        neg_q, neg_d;
    logic        sa_q, sa_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rdm_q, rdm_d;
    logic [2:0]  rwm_q, rwm_d;
    logic        valid_q, valid_d;

    // Operand decode on the incoming op
    logic        a_signed, b_signed, in_sa, in_sb;
    logic [31:0] in_mag_a, in_mag_b;
    logic        div_zero, div_ovf, special;
    logic [31:0] spec_res;

    always_comb begin
        a_signed = Funct3E[2] ? ~Funct3E[0] : (Funct3E[1:0] != 2'b11);
        b_signed = Funct3E[2] ? ~Funct3E[0] : ~Funct3E[1];
        in_sa    = a_signed & SrcAE[31];
        in_sb    = b_signed & SrcBE[31];
        in_mag_a = in_sa ? (32'd0 - SrcAE) : SrcAE;
        in_mag_b = in_sb ? (32'd0 - SrcBE) : SrcBE;
        div_zero = Funct3E[2] & (SrcBE == 32'd0);
        div_ovf  = Funct3E[2] & ~Funct3E[0] & (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);
        special  = div_zero | div_ovf;
        if (div_zero)
            spec_res = Funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
        else
            spec_res = Funct3E[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration of the datapath; acc holds {hi, lo} for both algorithms
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_tmp;
    logic        div_ok;
    logic [31:0] div_diff;
    logic [63:0] div_nxt;
    logic [63:0] acc_nxt;
    logic [63:0] prod_s;
    logic [31:0] quo_s, rem_s, mul_res, div_res, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
        mul_nxt  = {mul_sum, acc_q[31:1]};
        div_tmp  = {acc_q[63:32], acc_q[31]};
        div_ok   = (div_tmp >= {1'b0, mag_b_q});
        div_diff = div_tmp[31:0] - mag_b_q;
        div_nxt  = {(div_ok ? div_diff : div_tmp[31:0]), acc_q[30:0], div_ok};
        acc_nxt  = f3_q[2] ? div_nxt : mul_nxt;

        prod_s    = neg_q ? (64'd0 - acc_nxt) : acc_nxt;
        mul_res   = (f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
        quo_s     = neg_q ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
        rem_s     = sa_q ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
        div_res   = f3_q[1] ? rem_s : quo_s;
        final_res = f3_q[2] ? div_res : mul_res;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        acc_d    = acc_q;
        result_d = result_q;
        rdm_d    = rdm_q;
        rwm_d    = 3'b000;
        valid_d  = 1'b0;
        if (FlushE) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (StartE) begin
                        f3_d    = Funct3E;
                        rd_d    = RDE;
                        rw_d    = RegWriteE;
                        mag_a_d = in_mag_a;
                        mag_b_d = in_mag_b;
                        neg_d   = in_sa ^ in_sb;
                        sa_d    = in_sa;
                        if (special) begin
                            state_d  = S_DONE;
                            result_d = spec_res;
                            rdm_d    = RDE;
                            rwm_d    = RegWriteE;
                            valid_d  = 1'b1;
                        end else begin
                            state_d = S_CALC;
                            cnt_d   = 5'd0;
                            acc_d   = Funct3E[2] ? {32'd0, in_mag_a} : {32'd0, in_mag_b};
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_DONE;
                        result_d = final_res;
                        rdm_d    = rd_q;
                        rwm_d    = rw_q;
                        valid_d  = 1'b1;
                        cnt_d    = 5'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            f3_q     <= 3'd0;
            rd_q     <= 5'd0;
            rw_q     <= 3'd0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            rdm_q    <= 5'd0;
            rwm_q    <= 3'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rdm_q    <= rdm_d;
            rwm_q    <= rwm_d;
            valid_q  <= valid_d;
        end
    end

    // Drops in the final CALC cycle so upstream advances on the capture edge
    assign StallE = ~FlushE &
                    ((StartE & ((state_q == S_IDLE) | (state_q == S_DONE)) & ~special) |
                     ((state_q == S_CALC) & (cnt_q != 5'd31)));

    assign ResultM   = result_q;
    assign RDM       = rdm_q;
    assign RegWriteM = rwm_q;
    assign ValidM    = valid_q;

endmodule

// File: tb/tb_execute_muldiv_cycle.sv
// Directed bench for execute_muldiv_cycle: results, latency, stall shape, flush and reset.
module tb_execute_muldiv_cycle;

    logic        clk, rst;
    logic        StartE, FlushE;
    logic [2:0]  Funct3E, RegWriteE;
    logic [31:0] SrcAE, SrcBE;
    logic [4:0]  RDE;
    logic        StallE, ValidM;
    logic [31:0] ResultM;
    logic [4:0]  RDM;
    logic [2:0]  RegWriteM;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;

    execute_muldiv_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .StartE(StartE), .Funct3E(Funct3E),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .RDE(RDE), .RegWriteE(RegWriteE),
        .FlushE(FlushE), .StallE(StallE), .ResultM(ResultM), .RDM(RDM),
        .RegWriteM(RegWriteM), .ValidM(ValidM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives an op in the current cycle (called at posedge+1) and checks it to completion
    task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [2:0] rw,
                         input logic [31:0] exp, input bit spec, output int vcyc);
        bit ok;
        StartE = 1'b1; Funct3E = f3; SrcAE = a; SrcBE = b; RDE = rd; RegWriteE = rw;
        #1;
        chk({tag, "_stall_start"}, {31'd0, StallE}, spec ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        StartE = 1'b0;
        if (!spec) begin
            ok = 1'b1;
            for (int i = 1; i <= 32; i++) begin
                if (StallE !== ((i <= 31) ? 1'b1 : 1'b0) || ValidM !== 1'b0) ok = 1'b0;
                @(posedge clk); #1;
            end
            chk({tag, "_stall_shape"}, {31'd0, ok}, 32'd1);
        end
        chk({tag, "_valid"}, {31'd0, ValidM}, 32'd1);
        chk({tag, "_result"}, ResultM, exp);
        chk({tag, "_rd"}, {27'd0, RDM}, {27'd0, rd});
        chk({tag, "_rw"}, {29'd0, RegWriteM}, {29'd0, rw});
        vcyc = cyc;
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [2:0] rw,
                       input logic [31:0] exp, input bit spec);
        int vc;
        @(posedge clk); #1;
        issue(tag, f3, a, b, rd, rw, exp, spec, vc);
    endtask

    initial begin
        int v1, v2;
        bit seen;
        rst = 1'b1; StartE = 1'b0; FlushE = 1'b0; Funct3E = 3'd0;
        SrcAE = 32'd0; SrcBE = 32'd0; RDE = 5'd0; RegWriteE = 3'd0;
        #2;
        chk("rst_result", ResultM, 32'd0);
        chk("rst_rdm", {27'd0, RDM}, 32'd0);
        chk("rst_rw", {29'd0, RegWriteM}, 32'd0);
        chk("rst_valid", {31'd0, ValidM}, 32'd0);
        chk("rst_stall", {31'd0, StallE}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 3'b001, 32'hFFFF_FFEB, 1'b0);
        @(posedge clk); #1;
        chk("pulse_valid_low", {31'd0, ValidM}, 32'd0);
        chk("pulse_rw_zero", {29'd0, RegWriteM}, 32'd0);
        chk("pulse_result_hold", ResultM, 32'hFFFF_FFEB);

        run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 3'b010, 32'hFFFF_FFFE, 1'b0);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 3'b011, 32'hFFFF_FFFF, 1'b0);
        run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8, 3'b100, 32'h4000_0000, 1'b0);
        run("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 3'b001, 32'hFFFF_FFFD, 1'b0);
        run("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 3'b001, 32'hFFFF_FFFF, 1'b0);
        run("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd12, 3'b001, 32'd14, 1'b0);
        run("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd13, 3'b001, 32'd2, 1'b0);
        run("divu_by0", 3'b101, 32'd5, 32'd0, 5'd14, 3'b110, 32'hFFFF_FFFF, 1'b1);
        run("remu_by0", 3'b111, 32'd5, 32'd0, 5'd15, 3'b111, 32'd5, 1'b1);
        run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 3'b001, 32'h8000_0000, 1'b1);
        run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 3'b001, 32'd0, 1'b1);

        // Flush at cnt=10
        @(posedge clk); #1;
        StartE = 1'b1; Funct3E = 3'b000; SrcAE = 32'h1234; SrcBE = 32'h5678; RDE = 5'd20; RegWriteE = 3'b001;
        @(posedge clk); #1;
        StartE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_stall_before", {31'd0, StallE}, 32'd1);
        FlushE = 1'b1;
        #1;
        chk("flush_stall_during", {31'd0, StallE}, 32'd0);
        @(posedge clk); #1;
        FlushE = 1'b0;
        chk("flush_stall_after", {31'd0, StallE}, 32'd0);
        chk("flush_valid_after", {31'd0, ValidM}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ValidM !== 1'b0 || StallE !== 1'b0) seen = 1'b1;
        end
        chk("flush_no_valid", {31'd0, seen}, 32'd0);
        run("mul_3_4", 3'b000, 32'd3, 32'd4, 5'd9, 3'b101, 32'd12, 1'b0);

        // Reset mid-CALC
        @(posedge clk); #1;
        StartE = 1'b1; Funct3E = 3'b000; SrcAE = 32'd99; SrcBE = 32'd99; RDE = 5'd21; RegWriteE = 3'b001;
        @(posedge clk); #1;
        StartE = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_result", ResultM, 32'd0);
        chk("midrst_rdm", {27'd0, RDM}, 32'd0);
        chk("midrst_rw", {29'd0, RegWriteM}, 32'd0);
        chk("midrst_valid", {31'd0, ValidM}, 32'd0);
        chk("midrst_stall", {31'd0, StallE}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run("div_9_3", 3'b100, 32'd9, 32'd3, 5'd3, 3'b001, 32'd3, 1'b0);

        // Back-to-back: second op issued in the DONE cycle of the first
        @(posedge clk); #1;
        issue("b2b_mul", 3'b000, 32'd6, 32'd7, 5'd1, 3'b001, 32'd42, 1'b0, v1);
        issue("b2b_div", 3'b100, 32'hFFFF_FF9C, 32'd7, 5'd2, 3'b010, 32'hFFFF_FFF2, 1'b0, v2);
        chk("b2b_spacing", v2 - v1, 32'd33);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
